// File: rtl/ysyx_24070016_wbu_regfile_pkg.sv
// ysyx_24070016_wbu_regfile_pkg: shared widths, pending-entry type and halt states for the write-back unit
package ysyx_24070016_wbu_regfile_pkg;
    localparam int XLEN    = 32;
    localparam int NR_REGS = 32;
    localparam int AW      = 5;
    localparam int IW      = $clog2(NR_REGS);

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic            wen;
        logic [XLEN-1:0] result;
        logic            ebreak;
    } pend_t;

    typedef enum logic {RUN, HALTED} halt_state_e;

    // x0 and addresses beyond the implemented register count never hold data
    function automatic logic reg_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NR_REGS);
    endfunction
endpackage

// File: rtl/ysyx_24070016_wbu_regfile_if.sv
// ysyx_24070016_wbu_regfile_if: EXU result handshake and retire handshake bundle
interface ysyx_24070016_wbu_regfile_if;
    import ysyx_24070016_wbu_regfile_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rd;
    logic            in_wen;
    logic [XLEN-1:0] in_result;
    logic            in_ebreak;
    logic            retire_valid;
    logic            retire_ready;
    logic [AW-1:0]   retire_rd;
    logic [XLEN-1:0] retire_wdata;
    logic            retire_wen;

    modport master (
        output in_valid, in_rd, in_wen, in_result, in_ebreak, retire_ready,
        input  in_ready, retire_valid, retire_rd, retire_wdata, retire_wen
    );
    modport slave (
        input  in_valid, in_rd, in_wen, in_result, in_ebreak, retire_ready,
        output in_ready, retire_valid, retire_rd, retire_wdata, retire_wen
    );
endinterface

// File: rtl/ysyx_24070016_gpr_array.sv
// ysyx_24070016_gpr_array: GPR storage with one write port and two async read ports, x0 reads zero
module ysyx_24070016_gpr_array
    import ysyx_24070016_wbu_regfile_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] regs_q [NR_REGS];
    logic [XLEN-1:0] regs_d [NR_REGS];

    // next array contents: only a legal non-zero destination is ever written
    always_comb begin
        regs_d = regs_q;
        if (we && reg_ok(waddr)) regs_d[waddr[IW-1:0]] = wdata;
    end

    // storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    assign rdata1 = reg_ok(raddr1) ? regs_q[raddr1[IW-1:0]] : '0;
    assign rdata2 = reg_ok(raddr2) ? regs_q[raddr2[IW-1:0]] : '0;
endmodule

// File: rtl/ysyx_24070016_wbu_regfile.sv
// ysyx_24070016_wbu_regfile: 1-entry write-back stage committing EXU results to the GPRs, with operand forwarding and ebreak halt
module ysyx_24070016_wbu_regfile
    import ysyx_24070016_wbu_regfile_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    ysyx_24070016_wbu_regfile_if.slave           bus,
    input  logic [AW-1:0]                        rs1_addr,
    output logic [XLEN-1:0]                      rs1_data,
    input  logic [AW-1:0]                        rs2_addr,
    output logic [XLEN-1:0]                      rs2_data,
    output logic                                 halt,
    output logic [31:0]                          retire_cnt
);
    pend_t           pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    halt_state_e     state_q, state_d;
    logic            accept, retire;
    logic [XLEN-1:0] arr1, arr2;

    assign bus.in_ready     = rst_n && !halt && (!pend_valid_q || bus.retire_ready);
    assign accept           = bus.in_valid && bus.in_ready;
    assign retire           = pend_valid_q && bus.retire_ready;
    assign bus.retire_valid = pend_valid_q;
    assign bus.retire_rd    = pend_q.rd;
    assign bus.retire_wdata = pend_q.result;
    assign bus.retire_wen   = pend_q.wen;
    assign retire_cnt       = retire_cnt_q;

    // pending entry refill/drain and retirement counting
    always_comb begin
        pend_d       = accept ? '{rd: bus.in_rd, wen: bus.in_wen, result: bus.in_result, ebreak: bus.in_ebreak} : pend_q;
        pend_valid_d = accept || (pend_valid_q && !bus.retire_ready);
        retire_cnt_d = retire_cnt_q + {31'd0, retire};
    end

    // pending stage and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // halt state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // HALTED is entered when an ebreak retires and left only by reset
    always_comb begin
        state_d = (state_q == RUN && retire && pend_q.ebreak) ? HALTED : state_q;
    end

    // halt output decode
    always_comb begin
        halt = (state_q == HALTED);
    end

    ysyx_24070016_gpr_array u_gpr (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (retire && pend_q.wen),
        .waddr  (pend_q.rd),
        .wdata  (pend_q.result),
        .raddr1 (rs1_addr),
        .rdata1 (arr1),
        .raddr2 (rs2_addr),
        .rdata2 (arr2)
    );

    // read ports see the not-yet-committed pending result first
    always_comb begin
        rs1_data = !reg_ok(rs1_addr) ? '0 :
                   (pend_valid_q && pend_q.wen && pend_q.rd == rs1_addr) ? pend_q.result : arr1;
        rs2_data = !reg_ok(rs2_addr) ? '0 :
                   (pend_valid_q && pend_q.wen && pend_q.rd == rs2_addr) ? pend_q.result : arr2;
    end
endmodule

// File: tb/tb_ysyx_24070016_wbu_regfile.sv
// tb_ysyx_24070016_wbu_regfile: directed self-checking bench for the write-back stage and register file
module tb_ysyx_24070016_wbu_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, retire_cnt;
    logic        halt;
    int          checks = 0;
    int          failures = 0;

    ysyx_24070016_wbu_regfile_if bus();

    ysyx_24070016_wbu_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .halt       (halt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] val, input logic eb);
        bus.in_valid  = 1'b1;
        bus.in_rd     = rd;
        bus.in_wen    = wen;
        bus.in_result = val;
        bus.in_ebreak = eb;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_wen = 1'b0; bus.in_result = '0; bus.in_ebreak = 1'b0;
        bus.retire_ready = 1'b1;
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #3;
        chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
        chk("rs1_x5_reset", rs1_data, 32'd0);
        chk("halt_reset", {31'd0, halt}, 32'd0);
        chk("cnt_reset", retire_cnt, 32'd0);

        // basic accept, forward, then commit
        send(5'd3, 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rs1_addr = 5'd3; rs2_addr = 5'd3;
        #1;
        chk("retire_valid_pend", {31'd0, bus.retire_valid}, 32'd1);
        chk("retire_rd_pend", {27'd0, bus.retire_rd}, 32'd3);
        chk("rs1_fwd_x3", rs1_data, 32'hDEADBEEF);
        chk("rs2_fwd_x3", rs2_data, 32'hDEADBEEF);
        chk("cnt_before_retire", retire_cnt, 32'd0);
        tick();
        chk("rs1_array_x3", rs1_data, 32'hDEADBEEF);
        chk("retire_valid_drained", {31'd0, bus.retire_valid}, 32'd0);
        chk("cnt_1", retire_cnt, 32'd1);

        // x0 write is discarded but still counted
        send(5'd0, 1'b1, 32'h12345678, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rs1_addr = 5'd0;
        #1;
        chk("rs1_x0_pend", rs1_data, 32'd0);
        tick();
        chk("rs1_x0_after", rs1_data, 32'd0);
        chk("cnt_2", retire_cnt, 32'd2);

        // backpressure: entry holds, no accepts, then full-throughput drain
        bus.retire_ready = 1'b0;
        send(5'd4, 1'b1, 32'h44, 1'b0);
        tick();
        send(5'd5, 1'b1, 32'h55, 1'b0);
        rs1_addr = 5'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_rd", {27'd0, bus.retire_rd}, 32'd4);
            chk("stall_wdata", bus.retire_wdata, 32'h44);
            chk("stall_fwd_x4", rs1_data, 32'h44);
            tick();
        end
        chk("stall_cnt", retire_cnt, 32'd2);
        bus.retire_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("b2b_rd5", {27'd0, bus.retire_rd}, 32'd5);
        send(5'd6, 1'b1, 32'h66, 1'b0);
        #1;
        chk("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("b2b_rd6", {27'd0, bus.retire_rd}, 32'd6);
        chk("b2b_wdata6", bus.retire_wdata, 32'h66);
        tick();
        rs1_addr = 5'd4; rs2_addr = 5'd5;
        #1;
        chk("b2b_cnt", retire_cnt, 32'd5);
        chk("rs1_x4", rs1_data, 32'h44);
        chk("rs2_x5", rs2_data, 32'h55);

        // ebreak retires, writes x10 and halts
        send(5'd10, 1'b1, 32'h1, 1'b1);
        tick();
        bus.in_valid = 1'b0; bus.in_ebreak = 1'b0;
        #1;
        chk("halt_before_retire", {31'd0, halt}, 32'd0);
        tick();
        rs1_addr = 5'd10;
        #1;
        chk("halt_set", {31'd0, halt}, 32'd1);
        chk("halt_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rs1_x10", rs1_data, 32'h1);
        chk("cnt_6", retire_cnt, 32'd6);
        send(5'd11, 1'b1, 32'hBB, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("halt_no_accept", {31'd0, bus.retire_valid}, 32'd0);
        chk("halt_sticky", {31'd0, halt}, 32'd1);
        chk("halt_cnt_held", retire_cnt, 32'd6);
        rst_n = 1'b0;
        #1;
        chk("halt_cleared", {31'd0, halt}, 32'd0);
        chk("x10_cleared", rs1_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("in_ready_rerun", {31'd0, bus.in_ready}, 32'd1);

        // reset discards a waiting entry
        bus.retire_ready = 1'b0;
        send(5'd7, 1'b1, 32'hAA, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rs1_addr = 5'd7;
        #1;
        chk("x7_fwd", rs1_data, 32'hAA);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_pend", {31'd0, bus.retire_valid}, 32'd0);
        bus.retire_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("x7_not_written", rs1_data, 32'd0);
        chk("cnt_after_reset", retire_cnt, 32'd0);

        // retire counter wraps
        bus.retire_ready = 1'b0;
        send(5'd8, 1'b1, 32'h88, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        bus.retire_ready = 1'b1;
        rs1_addr = 5'd8;
        #1;
        chk("cnt_preload", retire_cnt, 32'hFFFFFFFF);
        tick();
        chk("cnt_wrap", retire_cnt, 32'd0);
        chk("rs1_x8", rs1_data, 32'h88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
